// File: rtl/instr_seq_pkg.sv
// Shared types and defaults for the instruction sequencer and its program store.
package instr_seq_pkg;

    localparam int DEFAULT_DEPTH = 16;
    localparam int DEFAULT_AW    = 4;
    localparam int DEFAULT_IW    = 6;

    localparam logic [DEFAULT_IW-1:0] NOP = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } seq_state_e;

endpackage

// File: rtl/prog_mem.sv
// Program store: synchronous-write, asynchronous-read register file with no reset.
module prog_mem
    import instr_seq_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = DEFAULT_AW,
    parameter int IW    = DEFAULT_IW
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [IW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [IW-1:0] rdata_o
);

    logic [IW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_sequencer.sv
// Loads a short program byte-serially, then streams one instruction per clock to the core,
// following the core's cjump and halting when the program counter leaves the loaded program.
module instr_sequencer
    import instr_seq_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = DEFAULT_AW,
    parameter int IW    = DEFAULT_IW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_clear,
    input  logic          load_valid,
    input  logic [IW-1:0] load_data,
    input  logic          run,
    input  logic          cjump,
    output logic [IW-1:0] instr,
    output logic          instr_valid,
    output logic [AW-1:0] pc,
    output logic          halted
);

    localparam logic [AW:0] FULL_LEN = (AW+1)'(DEPTH);

    seq_state_e    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [IW-1:0] instr_q, instr_d;
    logic          valid_q, valid_d;
    logic          halted_q, halted_d;
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW:0]   progLen_q, progLen_d;

    logic          memWe;
    logic [AW-1:0] rdAddr;
    logic [IW-1:0] rdData;
    logic [AW:0]   nextPc;

    // One extra bit so a fall-through past the last entry compares as out of range instead of wrapping.
    assign nextPc = cjump ? {1'b0, instr_q[AW-1:0]} : ({1'b0, pc_q} + (AW+1)'(1));
    assign rdAddr = (state_q == RUN) ? nextPc[AW-1:0] : '0;

    prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .IW    (IW)
    ) u_prog_mem (
        .clk     (clk),
        .we_i    (memWe),
        .waddr_i (wrPtr_q),
        .wdata_i (load_data),
        .raddr_i (rdAddr),
        .rdata_o (rdData)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            instr_q   <= IW'(NOP);
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
            wrPtr_q   <= '0;
            progLen_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            halted_q  <= halted_d;
            wrPtr_q   <= wrPtr_d;
            progLen_q <= progLen_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        halted_d  = halted_q;
        wrPtr_d   = wrPtr_q;
        progLen_d = progLen_q;
        memWe     = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_clear) begin
                    wrPtr_d   = '0;
                    progLen_d = '0;
                end else if (load_valid) begin
                    memWe     = 1'b1;
                    wrPtr_d   = wrPtr_q + AW'(1);
                    progLen_d = (progLen_q == FULL_LEN) ? FULL_LEN : progLen_q + (AW+1)'(1);
                end
                if (run && (progLen_q != '0)) begin
                    state_d = RUN;
                    pc_d    = '0;
                    instr_d = rdData;
                    valid_d = 1'b1;
                end
            end

            RUN: begin
                if (!run) begin
                    state_d  = IDLE;
                    pc_d     = '0;
                    instr_d  = IW'(NOP);
                    valid_d  = 1'b0;
                    halted_d = 1'b0;
                end else if (nextPc >= progLen_q) begin
                    state_d  = HALT;
                    instr_d  = IW'(NOP);
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                end else begin
                    pc_d    = nextPc[AW-1:0];
                    instr_d = rdData;
                end
            end

            HALT: begin
                if (!run) begin
                    state_d  = IDLE;
                    pc_d     = '0;
                    instr_d  = IW'(NOP);
                    valid_d  = 1'b0;
                    halted_d = 1'b0;
                end
            end

            default: begin
                state_d  = IDLE;
                pc_d     = '0;
                instr_d  = IW'(NOP);
                valid_d  = 1'b0;
                halted_d = 1'b0;
            end
        endcase
    end

    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus randomized runs
// compared against a cycle-level behavioural model of the program store and fetch rules.
module tb_instr_sequencer;

    logic       clk;
    logic       rst;
    logic       load_clear;
    logic       load_valid;
    logic [5:0] load_data;
    logic       run;
    logic       cjump;
    logic [5:0] instr;
    logic       instr_valid;
    logic [3:0] pc;
    logic       halted;

    int checks = 0;
    int errors = 0;

    // Behavioural model: mode 0 = idle, 1 = running, 2 = halted
    int mMem [16];
    int mLen, mWr, mMode, mPc, mInstr, mValid, mHalted;

    instr_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .load_clear  (load_clear),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .run         (run),
        .cjump       (cjump),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic modelReset();
        mLen = 0; mWr = 0; mMode = 0; mPc = 0; mInstr = 0; mValid = 0; mHalted = 0;
    endtask

    task automatic modelIdle();
        mMode = 0; mPc = 0; mInstr = 0; mValid = 0; mHalted = 0;
    endtask

    task automatic modelStep();
        int target;
        if (mMode == 0) begin
            if (run && mLen > 0) begin
                mMode = 1; mPc = 0; mInstr = mMem[0]; mValid = 1;
            end
            if (load_clear) begin
                mWr = 0; mLen = 0;
            end else if (load_valid) begin
                mMem[mWr] = int'(load_data);
                mWr = (mWr + 1) % 16;
                if (mLen < 16) mLen = mLen + 1;
            end
        end else if (!run) begin
            modelIdle();
        end else if (mMode == 1) begin
            target = cjump ? (mInstr % 16) : (mPc + 1);
            if (target >= mLen) begin
                mMode = 2; mInstr = 0; mValid = 0; mHalted = 1;
            end else begin
                mPc = target; mInstr = mMem[target];
            end
        end
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic clearStore();
        load_clear = 1'b1;
        tick();
        load_clear = 1'b0;
    endtask

    task automatic loadWord(input logic [5:0] data);
        load_valid = 1'b1;
        load_data  = data;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; load_clear = 1'b0; load_valid = 1'b0; load_data = '0; run = 1'b0; cjump = 1'b0;
        modelReset();
        #12;
        checks++; if (instr !== 6'h00) begin errors++; $display("[TB] FAIL reset_instr got %h want 00", instr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", instr_valid); end
        checks++; if (pc !== 4'h0) begin errors++; $display("[TB] FAIL reset_pc got %h want 0", pc); end
        checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted got %b want 0", halted); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        clearStore();
        loadWord(6'h01); loadWord(6'h02); loadWord(6'h03);
        run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (instr !== 6'(i + 1)) begin errors++; $display("[TB] FAIL basic_instr%0d got %h want %h", i, instr, i + 1); end
            checks++; if (pc !== 4'(i)) begin errors++; $display("[TB] FAIL basic_pc%0d got %0d want %0d", i, pc, i); end
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid%0d got %b want 1", i, instr_valid); end
        end
        tick();
        checks++; if (halted !== 1'b1) begin errors++; $display("[TB] FAIL basic_halted got %b want 1", halted); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_halt_valid got %b want 0", instr_valid); end
        checks++; if (instr !== 6'h00) begin errors++; $display("[TB] FAIL basic_halt_instr got %h want 00", instr); end
        tick();
        checks++; if (halted !== 1'b1 || pc !== 4'd2) begin errors++; $display("[TB] FAIL basic_halt_hold got halted=%b pc=%0d want 1/2", halted, pc); end
        run = 1'b0;
        tick();
    endtask

    task automatic test_jump();
        clearStore();
        loadWord(6'h11); loadWord(6'h20); loadWord(6'h05); loadWord(6'h3F);
        run = 1'b1;
        tick();
        tick();
        checks++; if (pc !== 4'd1 || instr !== 6'h20) begin errors++; $display("[TB] FAIL jump_pre got pc=%0d instr=%h want 1/20", pc, instr); end
        cjump = 1'b1;
        tick();
        cjump = 1'b0;
        checks++; if (pc !== 4'd0 || instr !== 6'h11) begin errors++; $display("[TB] FAIL jump_target got pc=%0d instr=%h want 0/11", pc, instr); end
        tick();
        checks++; if (pc !== 4'd1 || instr !== 6'h20) begin errors++; $display("[TB] FAIL jump_cont1 got pc=%0d instr=%h want 1/20", pc, instr); end
        tick();
        checks++; if (pc !== 4'd2 || instr !== 6'h05) begin errors++; $display("[TB] FAIL jump_cont2 got pc=%0d instr=%h want 2/05", pc, instr); end
        run = 1'b0;
        tick();
    endtask

    task automatic test_jump_oob();
        clearStore();
        loadWord(6'h2E); loadWord(6'h01); loadWord(6'h02); loadWord(6'h03);
        run = 1'b1;
        tick();
        checks++; if (instr !== 6'h2E) begin errors++; $display("[TB] FAIL oob_first got %h want 2E", instr); end
        cjump = 1'b1;
        tick();
        cjump = 1'b0;
        checks++; if (halted !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL oob_halt got halted=%b valid=%b want 1/0", halted, instr_valid); end
        checks++; if (pc !== 4'd0 || instr !== 6'h00) begin errors++; $display("[TB] FAIL oob_pc got pc=%0d instr=%h want 0/00", pc, instr); end
        tick();
        checks++; if (halted !== 1'b1 || pc !== 4'd0) begin errors++; $display("[TB] FAIL oob_hold got halted=%b pc=%0d want 1/0", halted, pc); end
        run = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        clearStore();
        for (int v = 0; v < 17; v++) loadWord(6'(v));
        run = 1'b1;
        tick();
        checks++; if (instr !== 6'd16 || pc !== 4'd0) begin errors++; $display("[TB] FAIL wrap_first got instr=%0d pc=%0d want 16/0", instr, pc); end
        for (int i = 1; i < 16; i++) begin
            tick();
            checks++; if (instr !== 6'(i) || pc !== 4'(i)) begin errors++; $display("[TB] FAIL wrap_word%0d got instr=%0d pc=%0d", i, instr, pc); end
        end
        tick();
        checks++; if (halted !== 1'b1 || pc !== 4'd15) begin errors++; $display("[TB] FAIL wrap_halt got halted=%b pc=%0d want 1/15", halted, pc); end
        run = 1'b0;
        tick();
    endtask

    task automatic test_drop_run();
        run = 1'b1;
        tick();
        load_valid = 1'b1;
        load_data  = 6'h3A;
        tick();
        load_valid = 1'b0;
        tick();
        checks++; if (pc !== 4'd2 || instr !== 6'd2) begin errors++; $display("[TB] FAIL drop_pre got pc=%0d instr=%0d want 2/2", pc, instr); end
        run = 1'b0;
        tick();
        checks++; if (pc !== 4'd0 || instr !== 6'h00 || instr_valid !== 1'b0 || halted !== 1'b0) begin
            errors++; $display("[TB] FAIL drop_idle got pc=%0d instr=%h valid=%b halted=%b", pc, instr, instr_valid, halted);
        end
        run = 1'b1;
        tick();
        checks++; if (pc !== 4'd0 || instr !== 6'd16 || instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL drop_restart got pc=%0d instr=%0d want 0/16", pc, instr); end
        tick();
        checks++; if (instr !== 6'd1) begin errors++; $display("[TB] FAIL drop_store got instr=%0d want 1", instr); end
        run = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        run = 1'b1;
        tick();
        tick();
        #3;
        rst = 1'b0;
        modelReset();
        #1;
        checks++; if (instr !== 6'h00 || instr_valid !== 1'b0 || pc !== 4'd0 || halted !== 1'b0) begin
            errors++; $display("[TB] FAIL areset_now got instr=%h valid=%b pc=%0d halted=%b", instr, instr_valid, pc, halted);
        end
        #2;
        rst = 1'b1;
        tick();
        checks++; if (instr_valid !== 1'b0 || halted !== 1'b0) begin errors++; $display("[TB] FAIL areset_norun got valid=%b halted=%b want 0/0", instr_valid, halted); end
        load_clear = 1'b1;
        load_valid = 1'b1;
        load_data  = 6'h05;
        tick();
        load_clear = 1'b0;
        load_valid = 1'b0;
        tick();
        checks++; if (instr_valid !== 1'b0 || instr !== 6'h00) begin errors++; $display("[TB] FAIL clear_prio got valid=%b instr=%h want 0/00", instr_valid, instr); end
        run = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int iter = 0; iter < 8; iter++) begin
            run = 1'b0;
            clearStore();
            for (int w = 0; w < int'($urandom_range(20, 1)); w++) loadWord(6'($urandom_range(63, 0)));
            run = 1'b1;
            for (int c = 0; c < 40; c++) begin
                cjump      = ($urandom_range(2, 0) == 0);
                run        = ($urandom_range(11, 0) != 0);
                load_valid = ($urandom_range(3, 0) == 0);
                load_data  = 6'($urandom_range(63, 0));
                tick();
                checks++; if (instr !== 6'(mInstr) || pc !== 4'(mPc) || instr_valid !== mValid[0] || halted !== mHalted[0]) begin
                    errors++;
                    $display("[TB] FAIL random_%0d_%0d got instr=%h pc=%0d valid=%b halted=%b want %h/%0d/%0d/%0d",
                             iter, c, instr, pc, instr_valid, halted, mInstr, mPc, mValid, mHalted);
                end
            end
            cjump      = 1'b0;
            load_valid = 1'b0;
            run        = 1'b0;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_jump();
        test_jump_oob();
        test_wrap();
        test_drop_run();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Program store and fetch sequencer that sits directly upstream of the `top` core. It loads a short program over a byte-serial load port, then streams one 6-bit instruction per clock into the core's `instr` input. It follows the core's `cjump` output to redirect the program counter, and halts cleanly at end-of-program. The core and its `io_out` path are unchanged; this block only replaces the external instruction driver.

## Interface
- `DEPTH`, 16: program store entries; must be a power of two.
- `AW`, 4: address width, equal to log2(`DEPTH`).
- `IW`, 6: instruction width; matches the core's `instr` port.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `load_clear`  in  1  in IDLE only: empties the store (`wr_ptr`=0, `prog_len`=0).
- `load_valid`  in  1  in IDLE only: write `load_data` at `wr_ptr`.
- `load_data`  in  IW  instruction word to store.
- `run`  in  1  level; high requests execution, low returns to IDLE.
- `cjump`  in  1  from the core: take a jump on the presented instruction.
- `instr`  out  IW  registered instruction to the core.
- `instr_valid`  out  1  high while `instr` holds a fetched word.
- `pc`  out  AW  address of the word currently on `instr`.
- `halted`  out  1  high in HALT.

## Operation
- States: IDLE, RUN, HALT. Encoding lives in the shared package.
- Reset values: IDLE, `pc`=0, `instr`=0, `instr_valid`=0, `halted`=0, `wr_ptr`=0, `prog_len`=0. Memory contents are undefined after reset and are never read beyond `prog_len`.
- IDLE:
  - `load_clear` has priority over `load_valid` in the same cycle.
  - `load_valid` writes `mem[wr_ptr]`, increments `wr_ptr` modulo `DEPTH`, and sets `prog_len` = min(`prog_len`+1, `DEPTH`).
  - After `DEPTH` writes the pointer wraps and overwrites entry 0. `prog_len` stays at `DEPTH`.
  - `run`=1 with `prog_len`>0 moves to RUN: `instr`<=`mem[0]`, `pc`<=0, `instr_valid`<=1.
  - `run`=1 with `prog_len`=0 is ignored; the block stays in IDLE.
- RUN, at each edge:
  - next = `cjump` ? `instr[AW-1:0]` : `pc`+1, computed at AW+1 bits with no wrap.
  - If next >= `prog_len`: go to HALT, `instr`<=0, `instr_valid`<=0, `halted`<=1, `pc` holds.
  - Otherwise: `pc`<=next, `instr`<=`mem[next]`.
- `run`=0 in RUN or HALT has priority over all other RUN/HALT updates. It returns to IDLE with `pc`=0, `instr`=0, `instr_valid`=0, `halted`=0. The program is retained.
- HALT: all outputs hold until `run`=0.
- `load_valid` and `load_clear` are ignored outside IDLE.
- Reset asserted mid-run: immediate return to reset values. `prog_len` is cleared, so a new program must be loaded.

## Timing
- Fetch latency is 1 cycle. On the first edge with `run`=1 in IDLE, `instr`/`instr_valid` update; the core sees word 0 in the following cycle.
- `cjump` is sampled on the same edge that retires the presented `instr`. A jump target is therefore fetched with no bubble, one word per cycle.
- A load write is visible to a RUN entry on the very next edge (write-then-run back to back is legal).
- `run` is level-sensitive; there is no edge detection.

## Structure
- Package `instr_seq_pkg`: state enum (IDLE/RUN/HALT), `DEPTH`/`AW`/`IW` defaults, NOP constant (all zeros).
- One sub-module, `prog_mem`: `DEPTH`x`IW` synchronous-write, asynchronous-read register file, not reset.
- The FSM, `wr_ptr`, `prog_len` and `pc` live in `instr_sequencer`.

## Test plan
- Reset, then load 0x01,0x02,0x03 and hold `run`=1 with `cjump`=0.
  - Required: `instr` = 0x01,0x02,0x03 on consecutive cycles with `pc`=0,1,2.
  - Then `halted`=1, `instr_valid`=0, `instr`=0.
- Load 0x11,0x20,0x05,0x3F, run, pulse `cjump` while `pc`=1 (`instr`=0x20).
  - Required: next `pc`=0, `instr`=0x11; sequence continues 0x20 …
- Jump target out of range: pulse `cjump` on word 0x2E with `prog_len`=4.
  - Required: target 14 >= 4, so HALT on that edge and `pc` holds.
- Load 17 words, values 0..16.
  - Required: `prog_len`=16 and `mem[0]`=16.
  - Run yields 16,1,2,…,15, then HALT.
- Drop `run` mid-RUN at `pc`=2, then reassert.
  - Required: IDLE with `pc`=0; restart presents `mem[0]`.
  - `load_valid` pulsed during RUN must not change the store.
- Assert `rst`=0 asynchronously mid-cycle during RUN.
  - Required: outputs zero immediately.
  - After release, `run`=1 stays in IDLE (`prog_len`=0).
  - `load_clear` and `load_valid` in the same cycle leave `prog_len`=0.
